// File: rtl/video_pkg.sv
// Shared constants for the video front end and the rotator: counter width default
// and the RGB packings the rotator buffer understands.
package video_pkg;

  localparam int CNT_W_DEF = 12;

  // Packed RGB widths: 2/2/2, 3/3/2, 3/3/3 and 4/4/4 bits per channel.
  localparam int DW_RGB222 = 6;
  localparam int DW_RGB332 = 8;
  localparam int DW_RGB333 = 9;
  localparam int DW_RGB444 = 12;

endpackage

// File: rtl/sync_polarity.sv
// Sync polarity detector: an integrator learns which level dominates and the
// registered output is always active-high.
module sync_polarity
  import video_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk_video,
  input  logic reset_n,
  input  logic in,
  output logic out,
  output logic pol
);

  localparam int IW = CNT_W + 4;
  localparam logic signed [IW-1:0] I_MAX = {1'b0, {(IW-1){1'b1}}};
  localparam logic signed [IW-1:0] I_MIN = {1'b1, {(IW-1){1'b0}}};
  localparam logic signed [IW-1:0] I_ONE = {{(IW-1){1'b0}}, 1'b1};

  logic signed [IW-1:0] integ;

  // A dominant-high sync is the idle level of an active-low pulse, so pol=1 inverts it.
  assign pol = !integ[IW-1] && (integ != '0);

  always_ff @(posedge clk_video) begin
    if (!reset_n) begin
      integ <= '0;
      out   <= 1'b0;
    end else begin
      if (in) begin
        if (integ != I_MAX) integ <= integ + I_ONE;
      end else begin
        if (integ != I_MIN) integ <= integ - I_ONE;
      end
      out <= in ^ pol;
    end
  end

endmodule

// File: rtl/video_input_conditioner.sv
// Video input conditioner: single-cycle pixel strobe, active-high aligned syncs,
// registered pixel data and per-frame geometry measurement with a stability flag.
module video_input_conditioner
  import video_pkg::*;
#(
  parameter int WIDTH    = 320,
  parameter int HEIGHT   = 240,
  parameter int DW       = 8,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int STABLE_N = 2
) (
  input  logic             clk_video,
  input  logic             reset_n,
  input  logic             ce_pix,
  input  logic [DW-1:0]    RGB_in,
  input  logic             HBlank,
  input  logic             VBlank,
  input  logic             HSync,
  input  logic             VSync,
  output logic             ce_out,
  output logic [DW-1:0]    RGB_out,
  output logic             hblank_out,
  output logic             vblank_out,
  output logic             hs_out,
  output logic             vs_out,
  output logic [CNT_W-1:0] meas_w,
  output logic [CNT_W-1:0] meas_h,
  output logic             frame_done,
  output logic             width_err,
  output logic             geom_ok
);

  localparam int SW = (STABLE_N < 1) ? 1 : $clog2(STABLE_N + 1);
  localparam logic [SW-1:0]    STAB_MAX = SW'(STABLE_N);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] WIDTH_C  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] HEIGHT_C = CNT_W'(HEIGHT);

  logic          ce_prev;
  logic [DW-1:0] rgb_d;
  logic          hblank_d;
  logic          vblank_d;
  logic          hs_corr;
  logic          vs_corr;
  logic [1:0]    pol_unused;

  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic [CNT_W-1:0] line_w;
  logic             err;
  logic [SW-1:0]    stab_cnt;

  logic             line_close;
  logic             frame_close;
  logic             active;
  logic [CNT_W-1:0] line_w_nx;
  logic [CNT_W-1:0] y_nx;
  logic             err_nx;
  logic             match;
  logic [SW-1:0]    stab_nx;

  sync_polarity #(.CNT_W(CNT_W)) u_hs_pol (
    .clk_video (clk_video),
    .reset_n   (reset_n),
    .in        (HSync),
    .out       (hs_corr),
    .pol       (pol_unused[0])
  );

  sync_polarity #(.CNT_W(CNT_W)) u_vs_pol (
    .clk_video (clk_video),
    .reset_n   (reset_n),
    .in        (VSync),
    .out       (vs_corr),
    .pol       (pol_unused[1])
  );

  // Every input is sampled on the ce_pix rising edge; the *_out registers hold the
  // previous pixel's blanking, so comparing against them yields the blank edges.
  always_comb begin
    active      = ~hblank_d & ~vblank_d;
    line_close  = ce_out & hblank_d & ~hblank_out & (x != '0);
    frame_close = ce_out & vblank_d & ~vblank_out;
    line_w_nx   = line_close ? x : line_w;
    y_nx        = (line_close && (y != CNT_MAX)) ? y + 1'b1 : y;
    err_nx      = err | (line_close & (y != '0) & (x != line_w));
    match       = (line_w_nx == WIDTH_C) & (y_nx == HEIGHT_C) & ~err_nx;
    stab_nx     = '0;
    if (match) stab_nx = (stab_cnt == STAB_MAX) ? stab_cnt : stab_cnt + 1'b1;
  end

  assign geom_ok = (stab_cnt == STAB_MAX);

  always_ff @(posedge clk_video) begin
    if (!reset_n) begin
      ce_prev    <= 1'b0;
      ce_out     <= 1'b0;
      rgb_d      <= '0;
      hblank_d   <= 1'b0;
      vblank_d   <= 1'b0;
      RGB_out    <= '0;
      hblank_out <= 1'b0;
      vblank_out <= 1'b0;
      hs_out     <= 1'b0;
      vs_out     <= 1'b0;
      frame_done <= 1'b0;
      meas_w     <= '0;
      meas_h     <= '0;
      width_err  <= 1'b0;
      stab_cnt   <= '0;
      x          <= '0;
      y          <= '0;
      line_w     <= '0;
      err        <= 1'b0;
    end else begin
      ce_prev    <= ce_pix;
      ce_out     <= ce_pix & ~ce_prev;
      rgb_d      <= RGB_in;
      hblank_d   <= HBlank;
      vblank_d   <= VBlank;
      frame_done <= frame_close;

      if (ce_out) begin
        RGB_out    <= rgb_d;
        hblank_out <= hblank_d;
        vblank_out <= vblank_d;
        hs_out     <= hs_corr;
        if (hs_corr && !hs_out) vs_out <= vs_corr;
      end

      line_w <= line_w_nx;
      // Frame close takes the just-closed line into account, then restarts the frame.
      if (frame_close) begin
        meas_w    <= line_w_nx;
        meas_h    <= y_nx;
        width_err <= err_nx;
        stab_cnt  <= stab_nx;
        x         <= '0;
        y         <= '0;
        err       <= 1'b0;
      end else begin
        y   <= y_nx;
        err <= err_nx;
        if (line_close) begin
          x <= '0;
        end else if (ce_out && active && (x != CNT_MAX)) begin
          x <= x + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_input_conditioner.sv
// Directed bench for video_input_conditioner on a reduced 16x8 raster (24x12 total),
// ce_pix 1-of-4, active-low syncs.
module tb_video_input_conditioner;

  localparam int W        = 16;
  localparam int H        = 8;
  localparam int DW       = 8;
  localparam int CNT_W    = 12;
  localparam int STABLE_N = 2;
  localparam int H_TOTAL  = 24;
  localparam int V_TOTAL  = 12;
  localparam int RW       = 2 * CNT_W + 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic             ce_pix;
  logic [DW-1:0]    RGB_in;
  logic             HBlank;
  logic             VBlank;
  logic             HSync;
  logic             VSync;
  logic             ce_out;
  logic [DW-1:0]    RGB_out;
  logic             hblank_out;
  logic             vblank_out;
  logic             hs_out;
  logic             vs_out;
  logic [CNT_W-1:0] meas_w;
  logic [CNT_W-1:0] meas_h;
  logic             frame_done;
  logic             width_err;
  logic             geom_ok;

  video_input_conditioner #(
    .WIDTH(W), .HEIGHT(H), .DW(DW), .CNT_W(CNT_W), .STABLE_N(STABLE_N)
  ) dut (
    .clk_video  (clk),
    .reset_n    (reset_n),
    .ce_pix     (ce_pix),
    .RGB_in     (RGB_in),
    .HBlank     (HBlank),
    .VBlank     (VBlank),
    .HSync      (HSync),
    .VSync      (VSync),
    .ce_out     (ce_out),
    .RGB_out    (RGB_out),
    .hblank_out (hblank_out),
    .vblank_out (vblank_out),
    .hs_out     (hs_out),
    .vs_out     (vs_out),
    .meas_w     (meas_w),
    .meas_h     (meas_h),
    .frame_done (frame_done),
    .width_err  (width_err),
    .geom_ok    (geom_ok)
  );

  typedef struct {
    int start;
    int w;
    int h;
    int odd_line;
    int odd_w;
    bit vb_early;
    int rst_line;
    int exp_w;
    int exp_h;
    bit exp_err;
    bit exp_ok;
  } frame_vec_t;

  localparam int N_VEC = 16;
  frame_vec_t vecs[N_VEC];

  // scoreboard
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] got_q[$];
  int checks = 0;
  int passes = 0;
  int ce_cnt = 0;

  always @(negedge clk) begin
    if (ce_out) ce_cnt++;
    if (frame_done) got_q.push_back({meas_w, meas_h, width_err, geom_ok});
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  function automatic frame_vec_t mk(int start, int w, int h, int odd_line, int odd_w,
                                    bit vb_early, int rst_line, int exp_w, int exp_h,
                                    bit exp_err, bit exp_ok);
    frame_vec_t v;
    v.start = start;    v.w = w;         v.h = h;
    v.odd_line = odd_line; v.odd_w = odd_w; v.vb_early = vb_early;
    v.rst_line = rst_line; v.exp_w = exp_w; v.exp_h = exp_h;
    v.exp_err = exp_err;   v.exp_ok = exp_ok;
    return v;
  endfunction

  function automatic logic [DW-1:0] pix_rgb(int line, int pix);
    return DW'(line * 7 + pix * 3);
  endfunction

  // driver tasks
  task automatic drive_pixel(input logic [DW-1:0] rgb, input logic hb, input logic vb,
                             input logic hs, input logic vs);
    RGB_in = rgb;
    HBlank = hb;
    VBlank = vb;
    HSync  = hs;
    VSync  = vs;
    ce_pix = 1'b1;
    @(posedge clk); #1;
    ce_pix = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ctl"}, 32'({ce_out, hblank_out, vblank_out, hs_out, vs_out,
                              frame_done, width_err, geom_ok, RGB_out}), 32'd0);
    check({tag, "_meas"}, 32'({meas_w, meas_h}), 32'd0);
  endtask

  task automatic pixel_checks(input int fi, input int line, input int pix);
    string t;
    t = $sformatf("f%0d", fi);
    if (line == 1 && pix == 5) begin
      check({t, "_rgb_out"}, 32'(RGB_out), 32'(pix_rgb(1, 5)));
      check({t, "_hblank_lo"}, 32'(hblank_out), 32'd0);
    end
    if (line == 1 && pix == 17) check({t, "_hblank_hi"}, 32'(hblank_out), 32'd1);
    if (line == 2 && pix == 5)  check({t, "_hs_idle"}, 32'(hs_out), 32'd0);
    if (line == 2 && pix == 19) check({t, "_hs_active"}, 32'(hs_out), 32'd1);
    if (line == 9 && pix == 12) begin
      check({t, "_vs_wait_line"}, 32'(vs_out), 32'd0);
      check({t, "_vblank_hi"}, 32'(vblank_out), 32'd1);
    end
    if (line == 9 && pix == 20)  check({t, "_vs_rise"}, 32'(vs_out), 32'd1);
    if (line == 11 && pix == 12) check({t, "_vs_hold"}, 32'(vs_out), 32'd1);
    if (line == 11 && pix == 20) check({t, "_vs_fall"}, 32'(vs_out), 32'd0);
  endtask

  task automatic drive_frame(input int fi, input frame_vec_t v);
    for (int line = v.start; line < V_TOTAL; line++) begin
      if (line == v.rst_line) begin
        reset_n = 1'b0;
        @(posedge clk); #1;
        check_reset_state($sformatf("f%0d_midreset", fi));
        reset_n = 1'b1;
      end
      for (int pix = 0; pix < H_TOTAL; pix++) begin
        int   lw;
        logic hb;
        logic vb;
        logic vs_act;
        lw     = (line == v.odd_line) ? v.odd_w : v.w;
        hb     = (pix >= lw);
        vb     = (line >= v.h) || (v.vb_early && line == v.h - 1 && pix >= lw);
        vs_act = (line == 9 && pix >= 10) || (line == 10) || (line == 11 && pix < 10);
        drive_pixel(pix_rgb(line, pix), hb, vb, !(pix >= 18 && pix <= 20), !vs_act);
        if (v.start == 0 && v.rst_line < 0) pixel_checks(fi, line, pix);
      end
    end
  endtask

  initial begin
    logic [RW-1:0] exp_r;
    logic [RW-1:0] got_r;

    reset_n = 1'b0;
    ce_pix  = 1'b0;
    RGB_in  = '0;
    HBlank  = 1'b0;
    VBlank  = 1'b0;
    HSync   = 1'b1;
    VSync   = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_reset_state("por");
    reset_n = 1'b1;

    //             start w   h  odd  oddw vbe rst  ew  eh err ok
    vecs[0]  = mk(8,    16, 8, -1,  0,   0,  -1,  0,  0, 0,  0);
    vecs[1]  = mk(0,    16, 8, -1,  0,   0,  -1,  16, 8, 0,  0);
    vecs[2]  = mk(0,    16, 8, -1,  0,   0,  -1,  16, 8, 0,  1);
    vecs[3]  = mk(0,    16, 8, -1,  0,   1,  -1,  16, 8, 0,  1);
    vecs[4]  = mk(0,    15, 8, -1,  0,   0,  -1,  15, 8, 0,  0);
    vecs[5]  = mk(0,    16, 8, -1,  0,   0,  -1,  16, 8, 0,  0);
    vecs[6]  = mk(0,    16, 8, -1,  0,   0,  -1,  16, 8, 0,  1);
    vecs[7]  = mk(0,    16, 8,  3,  14,  0,  -1,  16, 8, 1,  0);
    vecs[8]  = mk(0,    16, 8, -1,  0,   0,  -1,  16, 8, 0,  0);
    vecs[9]  = mk(0,    16, 8, -1,  0,   0,  -1,  16, 8, 0,  1);
    vecs[10] = mk(0,    16, 8,  7,  14,  0,  -1,  14, 8, 1,  0);
    vecs[11] = mk(0,    16, 7, -1,  0,   0,  -1,  16, 7, 0,  0);
    vecs[12] = mk(0,    16, 8, -1,  0,   0,  -1,  16, 8, 0,  0);
    vecs[13] = mk(0,    16, 8, -1,  0,   0,   3,  16, 5, 0,  0);
    vecs[14] = mk(0,    16, 8, -1,  0,   0,  -1,  16, 8, 0,  0);
    vecs[15] = mk(0,    16, 8, -1,  0,   0,  -1,  16, 8, 0,  1);

    for (int i = 0; i < N_VEC; i++) begin
      string t;
      t = $sformatf("f%0d", i);
      exp_q.push_back({CNT_W'(vecs[i].exp_w), CNT_W'(vecs[i].exp_h),
                       vecs[i].exp_err, vecs[i].exp_ok});
      ce_cnt = 0;
      got_q.delete();
      drive_frame(i, vecs[i]);
      check({t, "_ce_count"}, 32'(ce_cnt), 32'((V_TOTAL - vecs[i].start) * H_TOTAL));
      check({t, "_frame_done_count"}, 32'(got_q.size()), 32'd1);
      exp_r = exp_q.pop_front();
      got_r = (got_q.size() > 0) ? got_q.pop_front() : '1;
      check({t, "_meas_w"},    32'(got_r[RW-1 -: CNT_W]), 32'(exp_r[RW-1 -: CNT_W]));
      check({t, "_meas_h"},    32'(got_r[CNT_W+1 +: CNT_W]), 32'(exp_r[CNT_W+1 +: CNT_W]));
      check({t, "_width_err"}, 32'(got_r[1]), 32'(exp_r[1]));
      check({t, "_geom_ok"},   32'(got_r[0]), 32'(exp_r[0]));
    end

    // ce_pix held high for 10 cycles: a single strobe, new pixel captured
    ce_cnt = 0;
    RGB_in = 8'hA5;
    ce_pix = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    ce_pix = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("held_ce_pulses", 32'(ce_cnt), 32'd1);
    check("held_ce_rgb", 32'(RGB_out), 32'hA5);

    // ce_pix stuck low: outputs hold
    got_q.delete();
    RGB_in = 8'h3C;
    repeat (50) @(posedge clk);
    #1;
    check("stuck_ce_pulses", 32'(ce_cnt), 32'd1);
    check("stuck_rgb_hold", 32'(RGB_out), 32'hA5);
    check("stuck_no_frame", 32'(got_q.size()), 32'd0);
    check("stuck_geom_hold", 32'(geom_ok), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
